// File: rtl/prt_ingress_writer.sv
// Ingress stage in front of the PRT: claims a slot per packet, streams the packet words
// into it through the start/write/finish methods, then hands a descriptor to the classifier queue.
module prt_ingress_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 16,
  parameter int MAX_WORDS  = 64,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // packet stream
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  // PRT methods
  output logic                  EN_start_writing_prt_entry,
  input  logic                  RDY_start_writing_prt_entry,
  input  logic [SLOT_W-1:0]     start_writing_prt_entry,
  output logic                  EN_write_prt_entry,
  input  logic                  RDY_write_prt_entry,
  output logic [DATA_WIDTH-1:0] write_prt_entry_data,
  output logic                  EN_finish_writing_prt_entry,
  input  logic                  RDY_finish_writing_prt_entry,
  input  logic                  is_prt_slot_free,
  input  logic                  RDY_is_prt_slot_free,
  // descriptor to classifier
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [SLOT_W-1:0]     desc_slot,
  output logic [LEN_W-1:0]      desc_len,
  output logic                  desc_trunc,
  output logic [31:0]           pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FINISH,
    S_DESC
  } state_t;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_WORDS);

  state_t             state;
  state_t             state_nx;
  logic [SLOT_W-1:0]  slot_q;
  logic [LEN_W-1:0]   cnt;
  logic               trunc;
  logic               go;
  logic               room;
  logic               accept;
  logic               desc_take;

  assign go        = in_valid && is_prt_slot_free && RDY_is_prt_slot_free
                     && RDY_start_writing_prt_entry;
  assign room      = (cnt < MAX_CNT);
  assign accept    = in_valid && in_ready;
  assign desc_take = desc_valid && desc_ready;

  assign write_prt_entry_data = in_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (go) state_nx = S_STREAM;
      S_STREAM: if (accept && in_last) state_nx = S_FINISH;
      S_FINISH: if (RDY_finish_writing_prt_entry) state_nx = S_DESC;
      S_DESC:   if (desc_take) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Once the slot is full, words keep draining without touching the PRT so the
  // stream never stalls on a truncated packet.
  always_comb begin
    in_ready                    = 1'b0;
    EN_start_writing_prt_entry  = 1'b0;
    EN_write_prt_entry          = 1'b0;
    EN_finish_writing_prt_entry = 1'b0;
    unique case (state)
      S_IDLE: EN_start_writing_prt_entry = go;
      S_STREAM: begin
        in_ready           = room ? RDY_write_prt_entry : 1'b1;
        EN_write_prt_entry = in_valid && room && RDY_write_prt_entry;
      end
      S_FINISH: EN_finish_writing_prt_entry = RDY_finish_writing_prt_entry;
      default: ;
    endcase
  end

  // NOTE: only the control and descriptor flops carry a reset; the PRT clears its
  // own partial slot on rst, so no finish is issued for an aborted packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      cnt        <= '0;
      trunc      <= 1'b0;
      desc_valid <= 1'b0;
      desc_slot  <= '0;
      desc_len   <= '0;
      desc_trunc <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (EN_start_writing_prt_entry) begin
        slot_q <= start_writing_prt_entry;
        cnt    <= '0;
        trunc  <= 1'b0;
      end
      if (EN_write_prt_entry)  cnt   <= cnt + 1'b1;
      if (accept && !room)     trunc <= 1'b1;
      if (EN_finish_writing_prt_entry) begin
        desc_valid <= 1'b1;
        desc_slot  <= slot_q;
        desc_len   <= cnt;
        desc_trunc <= trunc;
      end else if (desc_take) begin
        desc_valid <= 1'b0;
        pkt_count  <= pkt_count + 32'd1;
      end
    end
  end

endmodule
